// File: rtl/delay_line_writer.sv
// Circular-buffer writer for the chorus delay line: stores one sample per
// handshake and returns the sample written `delay` samples earlier.
module delay_line_writer #(
    parameter int DEPTH = 4410
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic [15:0] delay,
    output logic        tap_valid,
    output logic [15:0] tap_data,
    output logic [15:0] wr_ptr,
    output logic [15:0] fill
);

    // state | meaning
    // IDLE  | waiting for a sample, in_ready high
    // WRITE | sample written to buffer, tap address computed
    // READ  | buffer read at tap address
    // OUT   | tap presented, write pointer advanced
    typedef enum logic [1:0] {IDLE, WRITE, READ, OUT} state_t;

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0] DEPTH16  = 16'(DEPTH);
    localparam logic [15:0] DEPTH_M1 = 16'(DEPTH - 1);

    state_t          state, state_nxt;
    logic [15:0]     sample_q;
    logic [15:0]     delay_q;
    logic [AW-1:0]   tap_addr;
    logic [AW-1:0]   tap_nxt;
    logic [15:0]     mem_q;
    logic [15:0]     mem [0:DEPTH-1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = WRITE;
            WRITE:   state_nxt = READ;
            READ:    state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready = (state == IDLE);

    // Both operands are below DEPTH, so the wrapped result always fits AW bits.
    always_comb begin
        if (wr_ptr >= delay_q) tap_nxt = AW'(wr_ptr - delay_q);
        else                   tap_nxt = AW'(wr_ptr + DEPTH16 - delay_q);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sample_q  <= '0;
            delay_q   <= '0;
            tap_addr  <= '0;
            wr_ptr    <= '0;
            fill      <= '0;
            tap_valid <= 1'b0;
            tap_data  <= '0;
        end else begin
            tap_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sample_q <= in_data;
                        delay_q  <= (delay >= DEPTH16) ? DEPTH_M1 : delay;
                    end
                end
                WRITE: begin
                    tap_addr <= tap_nxt;
                    if (fill != DEPTH16) fill <= fill + 16'd1;
                end
                OUT: begin
                    // Taps reaching back past the first write since reset read
                    // uninitialised memory, so they are forced to zero.
                    tap_data  <= (delay_q < fill) ? mem_q : 16'd0;
                    tap_valid <= 1'b1;
                    wr_ptr    <= (wr_ptr == DEPTH_M1) ? 16'd0 : wr_ptr + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Buffer RAM: no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (state == WRITE) mem[wr_ptr[AW-1:0]] <= sample_q;
        if (state == READ)  mem_q <= mem[tap_addr];
    end

endmodule

// File: tb/tb_delay_line_writer.sv
// Randomised scoreboard bench for delay_line_writer using a sample-history model.
module tb_delay_line_writer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [15:0] delay = '0;
    logic        tap_valid;
    logic [15:0] tap_data;
    logic [15:0] wr_ptr;
    logic [15:0] fill;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] data;
        logic [15:0] ptr;
        logic [15:0] fil;
        longint      t;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] hist[$];

    delay_line_writer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .delay(delay), .tap_valid(tap_valid),
        .tap_data(tap_data), .wr_ptr(wr_ptr), .fill(fill)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: tap = sample written d_eff writes ago, zero if that predates reset.
    task automatic model_accept(input logic [15:0] dat, input logic [15:0] d);
        exp_t e;
        int   n, de;
        hist.push_back(dat);
        n  = hist.size();
        de = (int'(d) >= DEPTH) ? DEPTH - 1 : int'(d);
        e.data = (de < n) ? hist[n-1-de] : 16'd0;
        e.ptr  = 16'(n % DEPTH);
        e.fil  = 16'((n < DEPTH) ? n : DEPTH);
        e.t    = longint'($time) + 35;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (resetn && tap_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tap actual=%h required=none at %0t", tap_data, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("tap_data", tap_data, e.data);
                check("wr_ptr", wr_ptr, e.ptr);
                check("fill", fill, e.fil);
                checks++;
                if (longint'($time) != e.t) begin
                    errors++;
                    $display("FAIL tap_latency actual=%0t required=%0d", $time, e.t);
                end
            end
        end
    end

    task automatic check_reset_values();
        check("rst_in_ready", {15'd0, in_ready}, 16'd1);
        check("rst_tap_valid", {15'd0, tap_valid}, 16'd0);
        check("rst_tap_data", tap_data, 16'd0);
        check("rst_wr_ptr", wr_ptr, 16'd0);
        check("rst_fill", fill, 16'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        exp_q.delete();
        hist.delete();
        @(negedge clk);
        check_reset_values();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = in_ready;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=0 required=1 at %0t", $time);
        end
    endtask

    task automatic send(input logic [15:0] dat, input logic [15:0] d, input bit hold);
        bit ok;
        wait_idle(ok);
        if (!ok) return;
        in_valid = 1'b1;
        in_data  = dat;
        delay    = d;
        @(posedge clk);
        model_accept(dat, d);
        #1;
        if (!hold) in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("busy_in_ready", {15'd0, in_ready}, 16'd0);
        end
        @(negedge clk);
        check("ready_return", {15'd0, in_ready}, 16'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        bit ok;
        repeat (2) @(negedge clk);
        check_reset_values();
        resetn = 1'b1;

        // held in_valid, d=0 latency
        send(16'h1234, 16'd0, 1'b1);

        // delay gating
        do_reset();
        for (int i = 1; i <= 12; i++) send(16'(i), 16'd5, 1'b0);

        // wrap-around and clamp
        do_reset();
        for (int i = 0; i < 20; i++) send(16'(100 + i), 16'd3, 1'b0);
        send(16'd200, 16'd50, 1'b0);
        send(16'd201, 16'd7, 1'b0);

        // mid-operation reset
        wait_idle(ok);
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        delay    = 16'd0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b0;
        exp_q.delete();
        hist.delete();
        @(negedge clk);
        check_reset_values();
        @(negedge clk);
        resetn = 1'b1;
        repeat (6) @(negedge clk);
        send(16'hBEEF, 16'd1, 1'b0);

        // random traffic
        for (int i = 0; i < 80; i++) begin
            logic [15:0] d;
            case ($urandom_range(0, 9))
                0:       d = 16'd50;
                1:       d = 16'hFFFF;
                2:       d = 16'($urandom);
                default: d = 16'($urandom_range(0, 9));
            endcase
            send(16'($urandom), d, 1'b0);
        end

        repeat (6) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_taps actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
